// File: rtl/special_case_encoder_if.sv
// Operand/result channel of the FPHUB special-case encoder.
// Carries both valid/ready handshakes; slave is the encoder's view.
interface special_case_encoder_if #(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int special_case = 7
) ();
    localparam int W  = E + M + 1;
    localparam int CW = $clog2(special_case);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  X;
    logic [W-1:0]  Y;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  X_out;
    logic [W-1:0]  Y_out;
    logic [CW-1:0] X_special_case;
    logic [CW-1:0] Y_special_case;
    logic          special_flag;

    modport slave (
        input  in_valid, X, Y, out_ready,
        output in_ready, out_valid, X_out, Y_out,
        output X_special_case, Y_special_case, special_flag
    );

    modport master (
        output in_valid, X, Y, out_ready,
        input  in_ready, out_valid, X_out, Y_out,
        input  X_special_case, Y_special_case, special_flag
    );
endinterface

// File: rtl/special_case_encoder.sv
// Classifies HUB operands X/Y into special-case codes for the adder.
// Two-stage elastic pipeline: s1 holds raw operands, s2 holds codes.
module special_case_encoder #(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int special_case = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    special_case_encoder_if.slave  bus
);
    localparam int W  = E + M + 1;
    localparam int CW = $clog2(special_case);

    localparam logic [W-1:0] P_INF  = {1'b0, {E{1'b1}}, {M{1'b1}}};
    localparam logic [W-1:0] N_INF  = {1'b1, {E{1'b1}}, {M{1'b1}}};
    localparam logic [W-1:0] P_ZERO = {W{1'b0}};
    localparam logic [W-1:0] N_ZERO = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] P_ONE  =
        {1'b0, 1'b1, {(E-1){1'b0}}, {M{1'b0}}};
    localparam logic [W-1:0] N_ONE  =
        {1'b1, 1'b1, {(E-1){1'b0}}, {M{1'b0}}};

    localparam logic [CW-1:0] C_NONE  = CW'(0);
    localparam logic [CW-1:0] C_PINF  = CW'(1);
    localparam logic [CW-1:0] C_NINF  = CW'(2);
    localparam logic [CW-1:0] C_PZERO = CW'(3);
    localparam logic [CW-1:0] C_NZERO = CW'(4);
    localparam logic [CW-1:0] C_PONE  = CW'(5);
    localparam logic [CW-1:0] C_NONE1 = CW'(6);

    function automatic logic [CW-1:0] classify(input logic [W-1:0] v);
        logic [CW-1:0] c;
        c = C_NONE;
        unique case (1'b1)
            v == P_INF:  c = C_PINF;
            v == N_INF:  c = C_NINF;
            v == P_ZERO: c = C_PZERO;
            v == N_ZERO: c = C_NZERO;
            v == P_ONE:  c = C_PONE;
            v == N_ONE:  c = C_NONE1;
            default:     c = C_NONE;
        endcase
        return c;
    endfunction

    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_x_q, s1_x_d;
    logic [W-1:0]  s1_y_q, s1_y_d;
    logic          s2_valid_q, s2_valid_d;
    logic [W-1:0]  s2_x_q, s2_x_d;
    logic [W-1:0]  s2_y_q, s2_y_d;
    logic [CW-1:0] s2_xc_q, s2_xc_d;
    logic [CW-1:0] s2_yc_q, s2_yc_d;
    logic          s2_flag_q, s2_flag_d;

    logic          s2_load;
    logic          s1_adv;
    logic          s1_load;
    logic [CW-1:0] xc;
    logic [CW-1:0] yc;

    assign s2_load = !s2_valid_q || bus.out_ready;
    assign s1_adv  = s1_valid_q && s2_load;
    assign s1_load = !s1_valid_q || s1_adv;
    assign xc      = classify(s1_x_q);
    assign yc      = classify(s1_y_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s2_valid_d = s2_valid_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;
        s2_xc_d    = s2_xc_q;
        s2_yc_d    = s2_yc_q;
        s2_flag_d  = s2_flag_q;
        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_x_d = bus.X;
                s1_y_d = bus.Y;
            end
        end
        // s2 data is only overwritten by a real pair, never by a bubble
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_x_d    = s1_x_q;
                s2_y_d    = s1_y_q;
                s2_xc_d   = xc;
                s2_yc_d   = yc;
                s2_flag_d = (xc != C_NONE) || (yc != C_NONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            s2_xc_q    <= '0;
            s2_yc_q    <= '0;
            s2_flag_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            s2_x_q     <= s2_x_d;
            s2_y_q     <= s2_y_d;
            s2_xc_q    <= s2_xc_d;
            s2_yc_q    <= s2_yc_d;
            s2_flag_q  <= s2_flag_d;
        end
    end

    assign bus.in_ready       = !rst && s1_load;
    assign bus.out_valid      = s2_valid_q;
    assign bus.X_out          = s2_x_q;
    assign bus.Y_out          = s2_y_q;
    assign bus.X_special_case = s2_xc_q;
    assign bus.Y_special_case = s2_yc_q;
    assign bus.special_flag   = s2_flag_q;
endmodule

// File: tb/tb_special_case_encoder.sv
// Directed and randomized checks of the special-case encoder,
// with a scoreboard on the default 32-bit instance.
module tb_special_case_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    special_case_encoder_if #(.M(23), .E(8), .special_case(7)) bus ();
    special_case_encoder_if #(.M(10), .E(5), .special_case(7)) sw ();

    special_case_encoder #(.M(23), .E(8), .special_case(7)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    special_case_encoder #(.M(10), .E(5), .special_case(7)) u_sweep (
        .clk (clk),
        .rst (rst),
        .bus (sw)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_out = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_code(input logic [31:0] v);
        case (v)
            32'h7FFF_FFFF: return 3'd1;
            32'hFFFF_FFFF: return 3'd2;
            32'h0000_0000: return 3'd3;
            32'h8000_0000: return 3'd4;
            32'h4000_0000: return 3'd5;
            32'hC000_0000: return 3'd6;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 9))
            0: return 32'h7FFF_FFFF;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'h8000_0000;
            4: return 32'h4000_0000;
            5: return 32'hC000_0000;
            6: return 32'h7F80_0000 | ($urandom & 32'h007F_FFFE);
            default: return $urandom;
        endcase
    endfunction

    // scoreboard + hold-stability monitor
    logic [63:0] sbq [$];
    logic        stall_q = 1'b0;
    logic [63:0] hold_d;
    logic [6:0]  hold_c;

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            sbq.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", {bus.X_out, bus.Y_out}, hold_d);
                chk("hold_code", 64'({bus.X_special_case,
                    bus.Y_special_case, bus.special_flag}),
                    64'(hold_c));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_data", {bus.X_out, bus.Y_out}, e);
                    chk("sb_code", 64'({bus.X_special_case,
                        bus.Y_special_case, bus.special_flag}),
                        64'({ref_code(e[63:32]), ref_code(e[31:0]),
                        (ref_code(e[63:32]) != 0) ||
                        (ref_code(e[31:0]) != 0)}));
                end
            end
            if (bus.in_valid && bus.in_ready)
                sbq.push_back({bus.X, bus.Y});
            stall_q = bus.out_valid && !bus.out_ready;
            hold_d  = {bus.X_out, bus.Y_out};
            hold_c  = {bus.X_special_case, bus.Y_special_case,
                       bus.special_flag};
        end
    end

    logic [31:0] sx [6];
    logic [31:0] sy [6];
    logic [2:0]  ex [6];
    logic [2:0]  ey [6];
    logic        ef [6];

    initial begin
        int k;
        int seq;
        int acc_n;
        int sent;
        int out0;
        logic acc;

        sx = '{32'h0000_0000, 32'h4000_0000, 32'h3F80_0000,
               32'h7F80_0000, 32'h8000_0001, 32'hFFFF_FFFF};
        sy = '{32'h8000_0000, 32'hC000_0000, 32'h1234_5678,
               32'h7FFF_FFFE, 32'h4000_0001, 32'h0000_0000};
        ex = '{3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd2};
        ey = '{3'd4, 3'd6, 3'd0, 3'd0, 3'd0, 3'd3};
        ef = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        bus.in_valid = 0; bus.X = '0; bus.Y = '0; bus.out_ready = 1;
        sw.in_valid = 0; sw.X = '0; sw.Y = '0; sw.out_ready = 1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", {bus.X_out, bus.Y_out}, 64'd0);
        chk("rst_flag", 64'(bus.special_flag), 64'd0);
        rst = 0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // single pair, two-stage latency
        @(posedge clk); #1;
        bus.in_valid = 1;
        bus.X = 32'h7FFF_FFFF;
        bus.Y = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.in_valid = 0;
        chk("lat_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_codes", 64'({bus.X_special_case, bus.Y_special_case}),
            64'({3'd1, 3'd2}));
        chk("lat_flag", 64'(bus.special_flag), 64'd1);
        chk("lat_data", {bus.X_out, bus.Y_out},
            64'h7FFF_FFFF_FFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;

        // back-to-back stream
        k = 0;
        bus.in_valid = 1; bus.X = sx[0]; bus.Y = sy[0];
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                if (k < 6) begin
                    chk("str_data", {bus.X_out, bus.Y_out},
                        {sx[k], sy[k]});
                    chk("str_code", 64'({bus.X_special_case,
                        bus.Y_special_case, bus.special_flag}),
                        64'({ex[k], ey[k], ef[k]}));
                end
                k++;
            end else if (k > 0 && k < 6) begin
                chk("str_gap", 64'd0, 64'd1);
            end
            if (c + 1 < 6) begin
                bus.X = sx[c+1]; bus.Y = sy[c+1];
            end else begin
                bus.in_valid = 0;
            end
        end
        chk("str_count", 64'(k), 64'd6);

        // backpressure: capacity two, hold, ordered release
        out0 = n_out;
        seq = 0; acc_n = 0;
        bus.out_ready = 0;
        bus.in_valid = 1;
        bus.X = 32'h1000_0000; bus.Y = ~bus.X;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                acc_n++; seq++;
                bus.X = 32'h1000_0000 + seq; bus.Y = ~bus.X;
            end
        end
        chk("bp_accepted", 64'(acc_n), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_head", 64'(bus.X_out), 64'h1000_0000);
        bus.out_ready = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                seq++;
                bus.X = 32'h1000_0000 + seq; bus.Y = ~bus.X;
            end
            if (seq >= 6) bus.in_valid = 0;
        end
        chk("bp_sent", 64'(seq), 64'd6);
        chk("bp_out_count", 64'(n_out - out0), 64'd6);
        chk("bp_drained", 64'(sbq.size()), 64'd0);

        // random valid/ready
        sent = 0;
        bus.in_valid = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            if (!bus.in_valid && $urandom_range(0, 9) < 8) begin
                bus.in_valid = 1;
                bus.X = rand_op();
                bus.Y = rand_op();
            end
            bus.out_ready = ($urandom_range(0, 9) >= 3);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                bus.in_valid = 0;
            end
        end
        chk("rand_sent", 64'(sent), 64'd1000);
        bus.out_ready = 1;
        for (int i = 0; i < 20 && sbq.size() != 0; i++)
            @(posedge clk);
        #1;
        chk("rand_drained", 64'(sbq.size()), 64'd0);

        // mid-stream reset drops in-flight pairs
        @(posedge clk); #1;
        bus.out_ready = 0;
        bus.in_valid = 1; bus.X = 32'h7FFF_FFFF; bus.Y = 32'h4000_0000;
        @(posedge clk); #1;
        bus.X = 32'hC000_0000; bus.Y = 32'h8000_0000;
        @(posedge clk); #1;
        bus.in_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        chk("mrst_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_data", {bus.X_out, bus.Y_out}, 64'd0);
        chk("mrst_code", 64'({bus.X_special_case, bus.Y_special_case,
            bus.special_flag}), 64'd0);
        chk("mrst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 0;
        bus.out_ready = 1;
        out0 = n_out;
        repeat (5) @(posedge clk);
        #1;
        chk("mrst_no_emit", 64'(n_out - out0), 64'd0);

        // narrow format M=10, E=5
        sw.in_valid = 1; sw.X = 16'h7FFF; sw.Y = 16'h4000;
        @(posedge clk); #1;
        sw.X = 16'h8000; sw.Y = 16'h0001;
        @(posedge clk); #1;
        sw.in_valid = 0;
        chk("sw_codes_a", 64'({sw.X_special_case, sw.Y_special_case,
            sw.special_flag}), 64'({3'd1, 3'd5, 1'b1}));
        @(posedge clk); #1;
        chk("sw_codes_b", 64'({sw.X_special_case, sw.Y_special_case,
            sw.special_flag}), 64'({3'd4, 3'd0, 1'b1}));
        chk("sw_data_b", 64'({sw.X_out, sw.Y_out}), 64'h8000_0001);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
